// File: rtl/multi_dataflow_engine_ctrl.sv
// Engine-side control stage: gates in1/in2 into the kernel, buffers results toward out_r, counts beats.
// Optional perf counters (perf_busy_o/perf_stall_o) when MULTI_DATAFLOW_ENGINE_PERF_EN is defined.
module multi_dataflow_engine_ctrl #(
  parameter int DATA_W         = 32,
  parameter int CNT_W          = 32,
  parameter int OUT_FIFO_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                enable_i,
  input  logic                start_i,
  input  logic [CNT_W-1:0]    cnt_limit_i,
  input  logic [1:0]          in_valid_i,
  output logic [1:0]          in_ready_o,
  input  logic [2*DATA_W-1:0] in_data_i,
  output logic [1:0]          kin_valid_o,
  input  logic [1:0]          kin_ready_i,
  output logic [2*DATA_W-1:0] kin_data_o,
  input  logic                kout_valid_i,
  output logic                kout_ready_o,
  input  logic [DATA_W-1:0]   kout_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DATA_W-1:0]   out_data_o,
  output logic [CNT_W-1:0]    cnt_out_o,
  output logic                ready_o,
`ifdef MULTI_DATAFLOW_ENGINE_PERF_EN
  output logic [CNT_W-1:0]    perf_busy_o,
  output logic [CNT_W-1:0]    perf_stall_o,
`endif
  output logic                done_o
);

  localparam int AW = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_lim, r_acc, r_cnt;
  logic [DATA_W-1:0]   r_mem [OUT_FIFO_DEPTH];
  logic [AW-1:0]       r_wptr, r_rptr;
  logic [AW:0]         r_count;

  logic w_gate, w_full, w_empty, w_push, w_pop, w_start;

  assign w_full  = (r_count == (AW+1)'(OUT_FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_gate  = (r_state == S_RUN) && (r_acc < r_lim);
  assign w_start = (r_state == S_IDLE) && start_i && !clear_i;
  assign w_push  = kout_valid_i && kout_ready_o;
  assign w_pop   = out_valid_o && out_ready_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; clear overrides everything including a same-cycle start
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_RUN;
      S_RUN:   if (r_cnt == r_lim) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (clear_i) w_next = S_IDLE;
  end

  // Output logic
  always_comb begin
    ready_o      = 1'b0;
    done_o       = 1'b0;
    kin_valid_o  = 2'b00;
    in_ready_o   = 2'b00;
    kin_data_o   = '0;
    kout_ready_o = 1'b0;
    case (r_state)
      S_IDLE: ready_o = 1'b1;
      S_RUN: begin
        kin_data_o   = in_data_i;
        kin_valid_o  = in_valid_i & {2{enable_i & w_gate}};
        in_ready_o   = kin_ready_i & {2{enable_i & w_gate}};
        kout_ready_o = enable_i && w_gate && !w_full;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign out_valid_o = !w_empty;
  assign out_data_o  = w_empty ? '0 : r_mem[r_rptr];
  assign cnt_out_o   = r_cnt;

  // Limit, beat counters and FIFO pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lim   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear_i) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_start) begin
      r_lim <= cnt_limit_i;
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
        r_acc  <= r_acc + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        if (r_cnt < r_lim) r_cnt <= r_cnt + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: out_data_o is masked while empty
  always_ff @(posedge clk_i) begin
    if (w_push && !clear_i) r_mem[r_wptr] <= kout_data_i;
  end

`ifdef MULTI_DATAFLOW_ENGINE_PERF_EN
  logic [CNT_W-1:0] r_busy, r_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy  <= '0;
      r_stall <= '0;
    end else if (clear_i || w_start) begin
      r_busy  <= '0;
      r_stall <= '0;
    end else if (r_state == S_RUN) begin
      if (r_busy != '1) r_busy <= r_busy + 1'b1;
      if (out_valid_o && !out_ready_i && (r_stall != '1)) r_stall <= r_stall + 1'b1;
    end
  end

  assign perf_busy_o  = r_busy;
  assign perf_stall_o = r_stall;
`endif

endmodule

// File: tb/tb_multi_dataflow_engine_ctrl.sv
// Directed bench for multi_dataflow_engine_ctrl: a transaction-level model (beat queue + job phase)
// is compared every cycle, plus literal checks on the headline scenarios.
module tb_multi_dataflow_engine_ctrl;
  localparam int DW = 32;
  localparam int CW = 32;
  localparam int DEPTH = 2;

  logic          clk_i = 0, rst_ni = 0, clear_i = 0, enable_i = 0, start_i = 0;
  logic [CW-1:0] cnt_limit_i = 0;
  logic [1:0]    in_valid_i = 0, kin_ready_i = 0;
  logic [2*DW-1:0] in_data_i = 0;
  logic          kout_valid_i = 0, out_ready_i = 0;
  logic [DW-1:0] kout_data_i = 0;
  logic [1:0]    in_ready_o, kin_valid_o;
  logic [2*DW-1:0] kin_data_o;
  logic          kout_ready_o, out_valid_o, ready_o, done_o;
  logic [DW-1:0] out_data_o;
  logic [CW-1:0] cnt_out_o;
`ifdef MULTI_DATAFLOW_ENGINE_PERF_EN
  logic [CW-1:0] perf_busy_o, perf_stall_o;
`endif

  multi_dataflow_engine_ctrl #(.DATA_W(DW), .CNT_W(CW), .OUT_FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i), .start_i(start_i),
    .cnt_limit_i(cnt_limit_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .kin_valid_o(kin_valid_o), .kin_ready_i(kin_ready_i),
    .kin_data_o(kin_data_o), .kout_valid_i(kout_valid_i), .kout_ready_o(kout_ready_o),
    .kout_data_i(kout_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .cnt_out_o(cnt_out_o), .ready_o(ready_o),
`ifdef MULTI_DATAFLOW_ENGINE_PERF_EN
    .perf_busy_o(perf_busy_o), .perf_stall_o(perf_stall_o),
`endif
    .done_o(done_o));

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: job phase 0=idle 1=run 2=done, accepted/delivered beat counts, queue of buffered beats
  int            m_ph = 0;
  logic [CW-1:0] m_lim = 0, m_acc = 0, m_cnt = 0, m_busy = 0, m_stall = 0;
  logic [DW-1:0] m_q[$];

  initial begin : compare
    bit            run, gate, e_kr, e_ov, push, pop;
    logic [CW-1:0] old_cnt;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        m_ph = 0; m_lim = 0; m_acc = 0; m_cnt = 0; m_busy = 0; m_stall = 0; m_q.delete();
      end
      run  = (m_ph == 1);
      gate = run && (m_acc < m_lim) && enable_i;
      e_kr = gate && (m_q.size() < DEPTH);
      e_ov = (m_q.size() > 0);
      chk("ready", ready_o, m_ph == 0);
      chk("done", done_o, m_ph == 2);
      chk("kin_valid", kin_valid_o, gate ? in_valid_i : 2'b00);
      chk("in_ready", in_ready_o, gate ? kin_ready_i : 2'b00);
      chk("kin_data", kin_data_o, run ? in_data_i : '0);
      chk("kout_ready", kout_ready_o, e_kr);
      chk("out_valid", out_valid_o, e_ov);
      chk("out_data", out_data_o, e_ov ? m_q[0] : '0);
      chk("cnt_out", cnt_out_o, m_cnt);
`ifdef MULTI_DATAFLOW_ENGINE_PERF_EN
      chk("perf_busy", perf_busy_o, m_busy);
      chk("perf_stall", perf_stall_o, m_stall);
`endif
      if (rst_ni) begin
        if (clear_i) begin
          m_ph = 0; m_acc = 0; m_cnt = 0; m_busy = 0; m_stall = 0; m_q.delete();
        end else begin
          push = kout_valid_i && e_kr;
          pop  = e_ov && out_ready_i;
          old_cnt = m_cnt;
          if (run) begin
            if (m_busy != '1) m_busy++;
            if (e_ov && !out_ready_i && m_stall != '1) m_stall++;
          end
          if (pop) begin
            void'(m_q.pop_front());
            if (m_cnt < m_lim) m_cnt++;
          end
          if (push) begin
            m_q.push_back(kout_data_i);
            m_acc++;
          end
          case (m_ph)
            0: if (start_i) begin
                 m_ph = 1; m_lim = cnt_limit_i; m_acc = 0; m_cnt = 0; m_busy = 0; m_stall = 0;
               end
            1: if (old_cnt == m_lim) m_ph = 2;
            default: m_ph = 0;
          endcase
        end
      end
    end
  end

  // One clock; kernel stub advances its data after each accepted result
  task automatic tick();
    bit khs;
    @(negedge clk_i);
    khs = kout_valid_i && kout_ready_o;
    @(posedge clk_i);
    #1;
    if (khs) kout_data_i = kout_data_i + 1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_o && n < budget) begin tick(); n++; end
    chk("done_timeout", done_o, 1'b1);
  endtask

  task automatic start_job(input logic [CW-1:0] lim);
    cnt_limit_i = lim; start_i = 1; tick(); start_i = 0;
  endtask

  initial begin : main
    logic [DW-1:0] beats[$];
    logic [CW-1:0] c0;
    int n;
    in_data_i = 64'hCAFE_0002_BEEF_0001;
    kout_data_i = 32'h10;
    repeat (3) tick();
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_cnt", cnt_out_o, 0);
    chk("rst_out_valid", out_valid_o, 1'b0);
    rst_ni = 1; tick();

    // 1: limit 4, free-flowing
    enable_i = 1; in_valid_i = 2'b11; kin_ready_i = 2'b11; kout_valid_i = 1; out_ready_i = 1;
    start_job(4);
    chk("t1_busy", ready_o, 1'b0);
    wait_done(40);
    chk("t1_cnt", cnt_out_o, 4);
    tick();
    chk("t1_done_once", done_o, 1'b0);
    chk("t1_ready", ready_o, 1'b1);
    chk("t1_cnt_hold", cnt_out_o, 4);

    // 2: limit 3, sink blocked until FIFO full
    kout_data_i = 32'h100; out_ready_i = 0;
    start_job(3);
    repeat (5) tick();
    chk("t2_full_kready", kout_ready_o, 1'b0);
    chk("t2_full_valid", out_valid_o, 1'b1);
    chk("t2_head", out_data_o, 32'h100);
    out_ready_i = 1; n = 0;
    while (!done_o && n < 20) begin
      if (out_valid_o && out_ready_i) beats.push_back(out_data_o);
      tick(); n++;
    end
    chk("t2_done", done_o, 1'b1);
    chk("t2_nbeats", beats.size(), 3);
    for (int i = 0; i < 3 && i < beats.size(); i++) chk("t2_beat", beats[i], 32'h100 + i);
    chk("t2_cnt", cnt_out_o, 3);
    tick();

    // 3: limit 0 completes with no traffic
    start_job(0);
    chk("t3_done_early", done_o, 1'b0);
    chk("t3_kready", kout_ready_o, 1'b0);
    tick();
    chk("t3_done_at2", done_o, 1'b1);
    tick();

    // 4: clear with simultaneous start mid-job
    start_job(8); n = 0;
    while (cnt_out_o != 2 && n < 20) begin tick(); n++; end
    chk("t4_reach2", cnt_out_o, 2);
    clear_i = 1; start_i = 1; tick(); clear_i = 0; start_i = 0;
    chk("t4_ready", ready_o, 1'b1);
    chk("t4_cnt", cnt_out_o, 0);
    chk("t4_empty", out_valid_o, 1'b0);
    repeat (3) begin tick(); chk("t4_no_done", done_o, 1'b0); end

    // 5: enable low with a full FIFO drains without accepting input
    out_ready_i = 0;
    start_job(6); n = 0;
    while (!(out_valid_o && !kout_ready_o) && n < 20) begin tick(); n++; end
    enable_i = 0; out_ready_i = 1; c0 = cnt_out_o;
    repeat (5) begin tick(); chk("t5_in_ready", in_ready_o, 2'b00); end
    chk("t5_drained", cnt_out_o, c0 + 2);
    chk("t5_empty", out_valid_o, 1'b0);
    enable_i = 1;
    wait_done(40);
    chk("t5_cnt", cnt_out_o, 6);
    tick();

`ifdef MULTI_DATAFLOW_ENGINE_PERF_EN
    // 6: exactly three stalled output cycles
    out_ready_i = 0;
    start_job(4); n = 0;
    while (!out_valid_o && n < 20) begin tick(); n++; end
    repeat (3) tick();
    out_ready_i = 1;
    wait_done(40);
    chk("t6_stall", perf_stall_o, 3);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
